// File: rtl/acc_uart_tx_pkg.sv
// acc_uart_tx_pkg -- shared definitions for the accumulator UART transmitter.
//   state_e     : framer FSM state encoding
//   DATA_BITS   : data bits per UART character
//   START_LVL   : line level of the start bit
//   STOP_LVL    : line level of the stop bit (and of the idle line)
//   FRAME_BITS  : total bit slots per character
//   even_parity : parity bit value for one data byte
// Build option: ACC_UART_TX_PARITY_EN adds an even-parity slot after the data bits.
package acc_uart_tx_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

`ifdef ACC_UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_e;
`endif

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/acc_uart_tx_byte.sv
// uart_tx_byte -- one-character UART framer.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   tick_i     : baud tick; the bit timer advances only on this pulse
//   start_i    : load data_i and begin a character (honoured in IDLE, and at the
//                end of a stop bit so characters can run back-to-back)
//   data_i     : byte to send, LSB first
//   tx_o       : registered serial line, idle high
//   stop_end_o : combinational, high on the tick that completes the stop bit
// Build option: ACC_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_byte
    import acc_uart_tx_pkg::*;
#(
    parameter int TICKS_PER_BIT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 stop_end_o
);

    localparam int             TW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

    state_e                 state_q;
    logic [TW-1:0]          tick_q;
    logic [2:0]             bit_q;
    logic [DATA_BITS-1:0]   sh_q;
    logic                   tx_q;
`ifdef ACC_UART_TX_PARITY_EN
    logic                   par_q;
`endif

    logic bit_end;

    // Last tick of the current bit slot.
    assign bit_end    = tick_i && (tick_q == TICK_LAST);
    assign stop_end_o = (state_q == S_STOP) && bit_end;
    assign tx_o       = tx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= STOP_LVL;
`ifdef ACC_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // Bit timer runs only while framing; it wraps on every slot boundary.
            if (state_q != S_IDLE && tick_i)
                tick_q <= bit_end ? '0 : tick_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_START;
                        tx_q    <= START_LVL;
                        sh_q    <= data_i;
                        bit_q   <= '0;
`ifdef ACC_UART_TX_PARITY_EN
                        par_q   <= even_parity(data_i);
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_q == BIT_LAST) begin
`ifdef ACC_UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= STOP_LVL;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end
                end
`ifdef ACC_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        tx_q    <= STOP_LVL;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        // Chained start skips IDLE so the next start bit follows with no gap.
                        if (start_i) begin
                            state_q <= S_START;
                            tx_q    <= START_LVL;
                            sh_q    <= data_i;
                            bit_q   <= '0;
`ifdef ACC_UART_TX_PARITY_EN
                            par_q   <= even_parity(data_i);
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/acc_uart_tx.sv
// acc_uart_tx -- sends an E_BITS accumulator snapshot as E_BITS/8 UART characters,
// least-significant byte first, with no idle gap between characters.
//   i_clock : clock, rising edge
//   i_reset : synchronous active-high reset (aborts any frame in flight)
//   i_tick  : one-cycle baud tick from the external baud generator
//   i_start : send request, taken only when idle and not in the o_done cycle
//   i_acc   : accumulator value, captured on the accepting edge
//   o_tx    : registered UART line, idle high
//   o_busy  : high from the accepting edge until the last stop bit completes
//   o_done  : one-cycle pulse as the transmitter returns to idle
// E_BITS must be a multiple of 8.
// Build option: ACC_UART_TX_PARITY_EN selects 11-bit frames with even parity.
module acc_uart_tx
    import acc_uart_tx_pkg::*;
#(
    parameter int E_BITS        = 16,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_tick,
    input  logic              i_start,
    input  logic [E_BITS-1:0] i_acc,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int             NBYTES    = E_BITS / 8;
    localparam int             CW        = $clog2(NBYTES + 1);
    localparam logic [CW-1:0]  LEFT_INIT = CW'(NBYTES - 1);

    logic [E_BITS-1:0]   shadow_q, shadow_d;
    logic [CW-1:0]       left_q,   left_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    // Zero-extended so the "next byte" slice is legal even for a one-byte accumulator.
    logic [E_BITS+7:0]   shadow_ext;
    logic                accept, stop_end, more, byte_start;
    logic [7:0]          byte_data;

    always_comb begin
        shadow_ext = {8'h00, shadow_q};
        // The done cycle is excluded so a held i_start restarts one cycle later.
        accept     = i_start && !busy_q && !done_q;
        more       = (left_q != '0);
        byte_start = accept || (stop_end && more);
        // First byte comes straight from i_acc; later bytes from the shifted shadow.
        byte_data  = accept ? i_acc[7:0] : shadow_ext[15:8];

        shadow_d = shadow_q;
        left_d   = left_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (accept) begin
            shadow_d = i_acc;
            left_d   = LEFT_INIT;
            busy_d   = 1'b1;
        end else if (stop_end && more) begin
            shadow_d = shadow_ext[E_BITS+7:8];
            left_d   = left_q - 1'b1;
        end else if (stop_end) begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shadow_q <= '0;
            left_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            left_q   <= left_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    uart_tx_byte #(
        .TICKS_PER_BIT (TICKS_PER_BIT)
    ) u_byte (
        .clk_i      (i_clock),
        .rst_i      (i_reset),
        .tick_i     (i_tick),
        .start_i    (byte_start),
        .data_i     (byte_data),
        .tx_o       (o_tx),
        .stop_end_o (stop_end)
    );

    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_acc_uart_tx.sv
module tb_acc_uart_tx;

    localparam int E_BITS = 16;
    localparam int TPB    = 16;
    localparam int NB     = E_BITS / 8;
`ifdef ACC_UART_TX_PARITY_EN
    localparam int FBITS  = 11;
`else
    localparam int FBITS  = 10;
`endif

    logic              i_clock = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_tick  = 1'b0;
    logic              i_start = 1'b0;
    logic [E_BITS-1:0] i_acc   = '0;
    wire               o_tx, o_busy, o_done;

    acc_uart_tx #(.E_BITS(E_BITS), .TICKS_PER_BIT(TPB)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_tick  (i_tick),
        .i_start (i_start),
        .i_acc   (i_acc),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clock = ~i_clock;

    // Baud tick every other cycle while enabled.
    bit tick_en = 1'b0;
    int tdiv    = 0;
    always @(posedge i_clock) begin
        #1;
        tdiv++;
        i_tick = tick_en && (tdiv % 2 == 0);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected bytes, pushed when a snapshot is requested.
    logic [7:0]  exp_q[$];
    bit          inframe    = 1'b0;
    int          tcnt       = 0;
    logic [10:0] fr         = '0;
    int          busy_ticks = 0;
    int          done_cnt   = 0;

    task automatic check_frame();
        logic [7:0] d;
        logic [7:0] e;
        d = fr[8:1];
        chk("start_bit", fr[0], 1'b0);
`ifdef ACC_UART_TX_PARITY_EN
        chk("parity_bit", fr[9], ^d);
`endif
        chk("stop_bit", fr[FBITS-1], 1'b1);
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("byte", d, e);
        end
    endtask

    // Line monitor: samples mid-bit by counting baud ticks from the start edge.
    always @(negedge i_clock) begin
        if (i_reset) begin
            inframe    = 1'b0;
            busy_ticks = 0;
            exp_q.delete();
        end else begin
            if (o_done) begin
                done_cnt++;
                chk("done_ticks", busy_ticks, FBITS * TPB * NB);
                chk("busy_at_done", o_busy, 1'b0);
                busy_ticks = 0;
            end
            if (o_busy && i_tick) busy_ticks++;
            if (!inframe && o_tx == 1'b0) begin
                inframe = 1'b1;
                tcnt    = 0;
            end
            if (inframe && i_tick) begin
                if (tcnt % TPB == TPB / 2) fr[tcnt / TPB] = o_tx;
                tcnt++;
                if (tcnt == (FBITS - 1) * TPB + TPB / 2 + 1) begin
                    check_frame();
                    inframe = 1'b0;
                end
            end
        end
    end

    task automatic start_snap(input logic [E_BITS-1:0] v);
        @(posedge i_clock); #1;
        i_acc   = v;
        i_start = 1'b1;
        for (int b = 0; b < NB; b++) exp_q.push_back(v[8*b +: 8]);
        @(posedge i_clock); #1;
        i_start = 1'b0;
        chk("lat_tx", o_tx, 1'b0);
        chk("lat_busy", o_busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge i_clock);
            k++;
        end while (!o_done && k < budget);
        chk(tag, o_done, 1'b1);
    endtask

    initial begin
        int d0;
        int bad;
        int k;
        logic tx0;

        tick_en = 1'b1;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        chk("rst_tx", o_tx, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        @(posedge i_clock); #1;
        i_reset = 1'b0;

        // Basic snapshot: 0x3C then 0xA5.
        start_snap(16'hA53C);
        wait_done("t1_done", 1500);
        repeat (5) @(negedge i_clock);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Parity pattern.
        start_snap(16'h0701);
        wait_done("t2_done", 1500);
        repeat (5) @(negedge i_clock);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Start request and i_acc change mid-frame must not disturb it.
        d0 = done_cnt;
        start_snap(16'hA53C);
        repeat (100) @(posedge i_clock); #1;
        i_start = 1'b1;
        i_acc   = 16'hFFFF;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        wait_done("t3_done", 1500);
        repeat (50) @(negedge i_clock);
        chk("t3_single_done", done_cnt - d0, 1);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Tick stall mid-bit: line and busy hold.
        start_snap(16'h5AC3);
        repeat (201) @(posedge i_clock); #1;
        tick_en = 1'b0;
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        tx0 = o_tx;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clock);
            if (o_tx !== tx0 || o_busy !== 1'b1 || o_done !== 1'b0) bad++;
        end
        chk("stall_changes", bad, 0);
        tick_en = 1'b1;
        wait_done("t4_done", 1500);
        repeat (5) @(negedge i_clock);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Reset at tick 5 of data bit 3.
        start_snap(16'hA53C);
        k = 0;
        while (busy_ticks < TPB * 4 + 5 && k < 1000) begin
            @(negedge i_clock);
            k++;
        end
        chk("t5_reach", busy_ticks >= TPB * 4 + 5, 1'b1);
        d0 = done_cnt;
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        chk("t5_rst_tx", o_tx, 1'b1);
        chk("t5_rst_busy", o_busy, 1'b0);
        chk("t5_rst_done", o_done, 1'b0);
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        repeat (50) @(negedge i_clock);
        chk("t5_no_done", done_cnt - d0, 0);
        start_snap(16'h1234);
        wait_done("t5_done", 1500);
        repeat (5) @(negedge i_clock);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Held start: back-to-back snapshots, restart one cycle after done.
        @(posedge i_clock); #1;
        i_acc   = 16'h0001;
        i_start = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < NB; b++) exp_q.push_back(i_acc[8*b +: 8]);
        wait_done("t6a_done", 1500);
        @(negedge i_clock);
        chk("t6_ignore_in_done", o_busy, 1'b0);
        @(negedge i_clock);
        chk("t6_restart", o_busy, 1'b1);
        wait_done("t6b_done", 1500);
        i_start = 1'b0;
        repeat (20) @(negedge i_clock);
        chk("t6_idle", o_busy, 1'b0);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_uart_tx.md
ACC_UART_TX -- requirements
Module: acc_uart_tx

Interface
REQ-001 Parameter E_BITS, default 16, accumulator width; SHALL be a multiple of 8.
REQ-002 Parameter TICKS_PER_BIT, default 16, baud ticks per UART bit.
REQ-003 i_clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  reset; synchronous, active-high.
REQ-005 i_tick  input  1  one-cycle baud tick pulse from the external baud generator.
REQ-006 i_start  input  1  request to send one accumulator snapshot.
REQ-007 i_acc  input  E_BITS  accumulator value to transmit.
REQ-008 o_tx  output  1  UART serial line, idle high.
REQ-009 o_busy  output  1  high from accepted start until the final stop bit completes.
REQ-010 o_done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-011 i_start SHALL be accepted only in IDLE; on acceptance i_acc SHALL be captured into a shadow register in the same edge, and later i_acc changes SHALL NOT affect the transmission.
REQ-012 i_start while o_busy=1 SHALL be ignored (no queueing).
REQ-013 The snapshot SHALL be sent as E_BITS/8 bytes, least-significant byte first.
REQ-014 Each byte SHALL be framed: start bit 0, 8 data bits LSB first, [parity per REQ-024], one stop bit 1.
REQ-015 Each bit SHALL last exactly TICKS_PER_BIT i_tick pulses; the bit-tick counter SHALL advance only on i_tick=1.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on accepted i_start; START->DATA after one bit time; DATA->PARITY (macro defined) or STOP after 8th data bit; PARITY->STOP after one bit time; STOP->START if bytes remain, else STOP->IDLE.
REQ-017 Consecutive bytes SHALL be back-to-back: next start bit begins on the cycle after the previous stop bit ends, no idle gap.
REQ-018 o_done SHALL pulse in the cycle the FSM returns to IDLE; o_busy SHALL fall in that same cycle.
REQ-019 A new i_start in the cycle o_done is high SHALL be ignored; accepted from the following cycle.
REQ-020 First start bit SHALL appear on o_tx in the cycle after acceptance, i.e. one-cycle latency from i_start.
REQ-021 o_tx SHALL be registered (glitch-free).

Reset
REQ-022 Reset SHALL force: state IDLE, o_tx=1, o_busy=0, o_done=0, bit/tick/byte counters 0, shadow register 0.
REQ-023 Reset asserted mid-frame SHALL abort immediately; o_tx returns to 1 on the next edge, no o_done pulse.

Configuration
REQ-024 Macro ACC_UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) SHALL follow the data bits (11-bit frame); when undefined, the PARITY state and logic SHALL be absent (10-bit frame).

Structure
REQ-025 Shared package SHALL hold the FSM state typedef/encodings and frame constants (DATA_BITS=8, START_LVL=0, STOP_LVL=1).
REQ-026 A single sub-module uart_tx_byte (one-byte framer with byte-level start/done handshake) is natural; acc_uart_tx sequences bytes around it.

Verification
REQ-027 i_acc=16'hA53C, i_start pulse, TICKS_PER_BIT=16 -> o_tx decodes bytes 0x3C then 0xA5; o_done after 20x16 ticks (22x16 with parity).
REQ-028 ACC_UART_TX_PARITY_EN defined, i_acc=16'h0701 -> parity bits 1 (0x01) then 1 (0x07); undefined -> no parity slot.
REQ-029 i_start during byte 0, and i_acc changed to 16'hFFFF mid-frame -> transmission unchanged, single o_done.
REQ-030 i_reset asserted at tick 5 of data bit 3 -> o_tx=1 next cycle, o_busy=0, no o_done; fresh i_start then sends a full frame.
REQ-031 i_start held high continuously with i_acc=16'h0001 -> back-to-back snapshots, restart only from the cycle after o_done.
REQ-032 i_tick stalled low for 100 cycles mid-bit -> o_tx holds its level, no state change.
